// File: rtl/mds_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the Twofish MDS multiplier.
package mds_pkg;

    localparam logic [8:0] GF_POLY = 9'h169;
    localparam logic [7:0] MDS_01  = 8'h01;
    localparam logic [7:0] MDS_5B  = 8'h5B;
    localparam logic [7:0] MDS_EF  = 8'hEF;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mds_state_e;

    // Multiply by x, reducing by GF_POLY.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

    // With a constant b this folds down to a fixed XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ s;
            s = gf_xtime(s);
        end
        return p;
    endfunction

    // Column coefficients packed as {z3, z2, z1, z0}.
    function automatic logic [31:0] col_coef(input logic [1:0] col);
        logic [31:0] c;
        case (col)
            2'd0:    c = {MDS_EF, MDS_EF, MDS_5B, MDS_01};
            2'd1:    c = {MDS_01, MDS_5B, MDS_EF, MDS_EF};
            2'd2:    c = {MDS_EF, MDS_01, MDS_EF, MDS_5B};
            default: c = {MDS_5B, MDS_EF, MDS_01, MDS_5B};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mds_col_mac.sv
// One MDS column: the 32-bit contribution of a single input byte for a given column.
module mds_col_mac
    import mds_pkg::*;
(
    input  logic [7:0]  y_i,
    input  logic [1:0]  col_i,
    output logic [31:0] contrib_o
);

    logic [7:0]  p01, p5b, pef;
    logic [31:0] coef;

    // Only three distinct constants exist, so form each product once and steer.
    assign p01  = gf_mul(y_i, MDS_01);
    assign p5b  = gf_mul(y_i, MDS_5B);
    assign pef  = gf_mul(y_i, MDS_EF);
    assign coef = col_coef(col_i);

    always_comb begin
        contrib_o = 32'h0;
        for (int r = 0; r < 4; r++) begin
            case (coef[8*r +: 8])
                MDS_01:  contrib_o[8*r +: 8] = p01;
                MDS_5B:  contrib_o[8*r +: 8] = p5b;
                default: contrib_o[8*r +: 8] = pef;
            endcase
        end
    end

endmodule

// File: rtl/mds_mult_seq.sv
// Sequential Twofish MDS multiplier, LANES columns per beat, valid/ready on both sides.
// Optional completion counter done_cnt is built when MDS_DONE_CNT_EN is defined.
module mds_mult_seq
    import mds_pkg::*;
#(
    parameter int LANES = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data
`ifdef MDS_DONE_CNT_EN
    ,
    output logic [CNT_W-1:0] done_cnt
`endif
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4) || CNT_W < 1) begin : g_bad_cfg
        $error("mds_mult_seq: LANES must be 1, 2 or 4 and CNT_W positive");
    end

    mds_state_e  state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [31:0] acc_q, acc_d;
    logic [1:0]  col_q, col_d;
    logic [31:0] lane_contrib [LANES];
    logic [31:0] beat_sum;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [1:0] lane_col;
        assign lane_col = col_q + 2'(l);
        mds_col_mac u_col (
            .y_i       (word_q[{lane_col, 3'b000} +: 8]),
            .col_i     (lane_col),
            .contrib_o (lane_contrib[l])
        );
    end

    always_comb begin
        beat_sum = 32'h0;
        for (int l = 0; l < LANES; l++) beat_sum = beat_sum ^ lane_contrib[l];
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        acc_d   = acc_q;
        col_d   = col_q;
        case (state_q)
            IDLE: if (in_valid) begin
                word_d  = in_data;
                acc_d   = 32'h0;
                col_d   = 2'd0;
                state_d = BUSY;
            end
            BUSY: begin
                acc_d = acc_q ^ beat_sum;
                col_d = col_q + 2'(LANES);
                if ({1'b0, col_q} == 3'(4 - LANES)) state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 32'h0;
            col_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            col_q   <= col_d;
        end
    end

    // The latched word is only read in BUSY, so it needs no reset.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;

`ifdef MDS_DONE_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst)                         cnt_q <= '0;
        else if (out_valid && out_ready) cnt_q <= cnt_q + 1'b1;
    end
    assign done_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mds_mult_seq.sv
// Directed bench for mds_mult_seq with LANES=1, 2 and 4 instances side by side.
module tb_mds_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic        out_ready [3];
    logic [31:0] in_data   [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [31:0] out_data  [3];
`ifdef MDS_DONE_CNT_EN
    logic [15:0] done_cnt  [3];
`endif
    int          exp_cnt   [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mds_mult_seq #(.LANES(1 << g), .CNT_W(16)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
`ifdef MDS_DONE_CNT_EN
            ,
            .done_cnt  (done_cnt[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_cnt(input int k, input string tag);
`ifdef MDS_DONE_CNT_EN
        check($sformatf("%s done_cnt L%0d", tag, k), 32'(done_cnt[k]), 32'(exp_cnt[k]));
`else
        if (k < 0) $display("bad lane index %0d for %s", k, tag);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int k, output int cyc);
        cyc = 0;
        while (!out_valid[k] && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic xfer(input int k, input logic [31:0] d, input logic [31:0] exp);
        int cyc;
        check($sformatf("idle in_ready L%0d %h", k, d), 32'(in_ready[k]), 32'd1);
        in_data[k]   = d;
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b1;
        tick();
        in_valid[k] = 1'b0;
        check($sformatf("busy in_ready L%0d %h", k, d), 32'(in_ready[k]), 32'd0);
        wait_valid(k, cyc);
        check($sformatf("latency L%0d %h", k, d), 32'(cyc), 32'(4 >> k));
        check($sformatf("out_data L%0d %h", k, d), out_data[k], exp);
        tick();
        exp_cnt[k]++;
        out_ready[k] = 1'b0;
        check($sformatf("out_valid drop L%0d %h", k, d), 32'(out_valid[k]), 32'd0);
        check($sformatf("in_ready back L%0d %h", k, d), 32'(in_ready[k]), 32'd1);
        check_cnt(k, "xfer");
    endtask

    task automatic backpressure(input int k, input logic [31:0] d, input logic [31:0] exp);
        int cyc;
        int stray;
        in_data[k]   = d;
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b0;
        tick();
        in_valid[k] = 1'b0;
        wait_valid(k, cyc);
        check($sformatf("bp latency L%0d", k), 32'(cyc), 32'(4 >> k));
        for (int i = 0; i < 10; i++) begin
            in_valid[k] = 1'b1;
            in_data[k]  = ~d;
            tick();
            check($sformatf("bp hold data L%0d c%0d", k, i), out_data[k], exp);
            check($sformatf("bp in_ready L%0d c%0d", k, i), 32'(in_ready[k]), 32'd0);
            check($sformatf("bp out_valid L%0d c%0d", k, i), 32'(out_valid[k]), 32'd1);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        exp_cnt[k]++;
        check($sformatf("bp release valid L%0d", k), 32'(out_valid[k]), 32'd0);
        check($sformatf("bp release ready L%0d", k), 32'(in_ready[k]), 32'd1);
        check_cnt(k, "bp");
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid[k] || !in_ready[k]) stray++;
        end
        check($sformatf("bp single transfer L%0d", k), 32'(stray), 32'd0);
        check_cnt(k, "bp after");
    endtask

    logic [31:0] vin  [6] = '{32'h00000001, 32'h00000100, 32'h00000101,
                              32'h00000002, 32'h01000000, 32'h01010101};
    logic [31:0] vexp [6] = '{32'hEFEF5B01, 32'h015BEFEF, 32'hEEB4B4EE,
                              32'hB7B7B602, 32'h5BEF015B, 32'h5A5A5AEE};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            in_data[k]   = 32'h0;
            exp_cnt[k]   = 0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset out_valid L%0d", k), 32'(out_valid[k]), 32'd0);
            check($sformatf("reset in_ready L%0d", k), 32'(in_ready[k]), 32'd1);
            check($sformatf("reset out_data L%0d", k), out_data[k], 32'h0);
            check_cnt(k, "reset");
        end
        rst = 1'b0;

        // Abort a LANES=1 transform on its second BUSY cycle, with a word offered during reset.
        in_data[0]  = 32'h00000001;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        rst         = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h00000005;
        tick();
        rst         = 1'b0;
        in_valid[0] = 1'b0;
        check("abort out_valid", 32'(out_valid[0]), 32'd0);
        check("abort in_ready", 32'(in_ready[0]), 32'd1);
        check("abort out_data", out_data[0], 32'h0);
        check_cnt(0, "abort");
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (out_valid[0] || !in_ready[0]) seen++;
            end
            check("abort no output", 32'(seen), 32'd0);
        end

        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 6; v++) xfer(k, vin[v], vexp[v]);
            backpressure(k, 32'h00000002, 32'hB7B7B602);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
